// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU fetch and data ports (optional MEM_ARBITER_STARVE_GUARD_EN)
module mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t rd_owner;
    owner_t rd_owner_nxt;
    logic   force_if;

    // Only the word-address bits reach the RAM; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    assign force_if = if_req && (wait_cnt == WAIT_W'(MAX_WAIT));

    // Count consecutive denied fetch cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;
    assign force_if = 1'b0;
`endif

    // Grant: data wins unless the fetch port has been starved; nothing during reset.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (rst_n) begin
            d_gnt  = d_req && !force_if;
            if_gnt = if_req && !d_gnt;
        end
    end

    // Drive the RAM from whichever port was granted; idle bus is all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end
    end

    // Next read owner: the granted read source, NONE for writes or idle.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (d_gnt && (d_we == 4'b0000)) begin
            rd_owner_nxt = OWN_D;
        end else if (if_gnt) begin
            rd_owner_nxt = OWN_IF;
        end
    end

    // Read-owner register; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    assign if_rvalid = (rd_owner == OWN_IF);
    assign d_rvalid  = (rd_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] sb_if [$];
    logic [31:0] sb_d  [$];

    mem_arbiter #(.ADDR_W(10), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM with byte enables and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs against expectations; maintains scoreboard and reference memory.
    task automatic check(input logic e_ig, input logic e_dg, input logic e_irv, input logic e_drv);
        logic        e_en;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        logic [31:0] exp_val;
        #1;
        e_en   = e_ig | e_dg;
        e_addr = e_dg ? {22'h0, d_addr[11:2]} : (e_ig ? {22'h0, if_addr[11:2]} : 32'h0);
        e_we   = e_dg ? d_we : 4'b0000;
        e_wd   = e_en ? d_wdata : 32'h0;
        chk("if_gnt",    {31'h0, if_gnt},    {31'h0, e_ig});
        chk("d_gnt",     {31'h0, d_gnt},     {31'h0, e_dg});
        chk("mem_en",    {31'h0, mem_en},    {31'h0, e_en});
        chk("mem_addr",  {22'h0, mem_addr},  e_addr);
        chk("mem_we",    {28'h0, mem_we},    {28'h0, e_we});
        chk("mem_wdata", mem_wdata,          e_wd);
        chk("if_rvalid", {31'h0, if_rvalid}, {31'h0, e_irv});
        chk("d_rvalid",  {31'h0, d_rvalid},  {31'h0, e_drv});
        if (e_irv) begin
            if (sb_if.size() == 0) chk("sb_if_underflow", 32'h1, 32'h0);
            else begin
                exp_val = sb_if.pop_front();
                chk("if_rdata", if_rdata, exp_val);
            end
        end else begin
            chk("if_rdata_idle", if_rdata, 32'h0);
        end
        if (e_drv) begin
            if (sb_d.size() == 0) chk("sb_d_underflow", 32'h1, 32'h0);
            else begin
                exp_val = sb_d.pop_front();
                chk("d_rdata", d_rdata, exp_val);
            end
        end else begin
            chk("d_rdata_idle", d_rdata, 32'h0);
        end
        if (e_ig) sb_if.push_back(ref_mem[if_addr[11:2]]);
        if (e_dg && d_we == 4'b0000) sb_d.push_back(ref_mem[d_addr[11:2]]);
        if (e_dg && d_we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (d_we[b]) ref_mem[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
        end
    endtask

    task automatic step(input logic e_ig, input logic e_dg, input logic e_irv, input logic e_drv);
        check(e_ig, e_dg, e_irv, e_drv);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 32'hC0DE0000 + i * 32'h00010003;
            ref_mem[i] = 32'hC0DE0000 + i * 32'h00010003;
        end
        mem_rdata = 32'h0;
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0;
        d_req   = 1'b1;
        d_addr  = 32'h0;
        d_we    = 4'b0000;
        d_wdata = 32'h0;

        // Reset: requests present but nothing granted, no rvalid.
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;

        // Fetch only.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        check(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fetch_mem_addr", {22'h0, mem_addr}, 32'd4);
        @(negedge clk);
        if_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Data write then read-back.
        d_req = 1'b1; d_addr = 32'h20; d_we = 4'b0011; d_wdata = 32'h0000_ABCD;
        check(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wr_mem_addr", {22'h0, mem_addr}, 32'd8);
        @(negedge clk);
        d_we = 4'b0000; d_wdata = 32'h0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        d_req = 1'b0;
        check(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wr_rd_low_half", {16'h0, d_rdata[15:0]}, 32'h0000_ABCD);
        @(negedge clk);

        // Contention: data first, fetch waits then proceeds.
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h44;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        d_req = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        if_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Starvation: data held with fetch pending.
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_addr = 32'h0C;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, i > 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, i > 0);
`endif
        if_req = 1'b0; d_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a read: the read is dropped.
        if_req = 1'b1; if_addr = 32'h14;
        check(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
        sb_if.delete();
        @(negedge clk);
        check(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        if_addr = 32'h4;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        if_req = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Aliasing of high address bits.
        d_req = 1'b1; d_addr = 32'h0000_1004; d_we = 4'b0000;
        check(1'b0, 1'b1, 1'b0, 1'b0);
        chk("alias_mem_addr", {22'h0, mem_addr}, 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        chk("sb_if_empty", sb_if.size(), 32'd0);
        chk("sb_d_empty",  sb_d.size(),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between the CPU instruction-fetch port and the CPU data port.
- Sits between the cpu core and a unified BRAM, replacing the separate instruction and data memories.
- Arbitrates one access per cycle with fixed data-over-fetch priority.
- Issues a request/grant handshake so the core can stall, and routes 1-cycle-latency read data back to its owner.

Parameters:
- ADDR_W, 10, word-address width of the RAM (1024 words).
- MAX_WAIT, 4, consecutive denied fetch cycles before the fetch port is forced ahead (only with STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetch data.
- d_req  in  1  data request.
- d_addr  in  32  data byte address.
- d_we  in  4  byte write enables; 0 means read.
- d_wdata  in  32  write data, already lane-aligned.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  data read valid.
- d_rdata  out  32  data read value.
- mem_en  out  1  RAM access strobe.
- mem_addr  out  ADDR_W  RAM word address.
- mem_we  out  4  RAM byte write enables.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we==0.

Behaviour:
- Grant logic is combinational in the cycle of the request.
  - At most one of if_gnt and d_gnt is high.
  - Default priority: d_req wins over if_req.
  - A requester holds req, addr, we and wdata stable until it sees gnt.
- On a grant:
  - mem_en=1.
  - mem_addr = granted addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored, so higher addresses alias.
  - mem_we = d_we for a data grant, 0 for a fetch grant.
  - mem_wdata = d_wdata.
- With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read tracking:
  - Register rd_owner is one of {NONE, IF, D}.
  - At each clock edge it is set to the granted read source, or NONE if there was no grant or the grant was a write.
  - if_rvalid = (rd_owner==IF) and d_rvalid = (rd_owner==D). Both are registered, giving 1-cycle read latency.
- Read data routing:
  - if_rdata = mem_rdata when if_rvalid, else 0.
  - d_rdata = mem_rdata when d_rvalid, else 0.
- Writes produce no rvalid. The write completes at the granting edge.
- Pipelined operation: a new grant may issue in the same cycle an rvalid is returned, giving back-to-back throughput of one access per cycle.
- Simultaneous d_req and if_req: data is granted and fetch waits. The fetch request stays pending without loss.
- Reset: rst_n low asynchronously forces the following, including mid-access; an in-flight read is dropped without any rvalid.
  - rd_owner=NONE, if_rvalid=0, d_rvalid=0.
  - Wait counter = 0.
  - mem_en, if_gnt, d_gnt = 0.
- The first grant is possible in the first cycle after rst_n deasserts.

Optional Feature:
- Macro: MEM_ARBITER_STARVE_GUARD_EN.
- Defined:
  - A counter wait_cnt (clog2(MAX_WAIT+1) bits) increments each cycle if_req=1 and if_gnt=0.
  - It clears on if_gnt or when if_req=0.
  - When wait_cnt==MAX_WAIT, the fetch port has priority over data for that cycle; d_gnt=0 and the counter clears after the grant.
  - wait_cnt saturates at MAX_WAIT.
- Undefined: strict data priority with no counter logic; fetch can starve indefinitely.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x0000_0010 -> same cycle if_gnt=1, mem_en=1, mem_addr=4, mem_we=0; next cycle if_rvalid=1, if_rdata=RAM[4].
2. Data write then read: d_req=1, d_addr=0x20, d_we=4'b0011, d_wdata=0x0000_ABCD -> d_gnt=1, mem_we=0011, mem_addr=8, no d_rvalid. Then a read of 0x20 -> d_rvalid=1 next cycle, low half of d_rdata = 0xABCD.
3. Contention: if_req and d_req high together, d_we=0 -> cycle0 d_gnt only; cycle1 d_rvalid=1 and if_gnt=1 (d_req dropped); cycle2 if_rvalid=1.
4. Starvation guard: macro defined, MAX_WAIT=4, d_req held high with if_req high -> d_gnt for 4 cycles, 5th cycle if_gnt=1 and d_gnt=0, then data resumes. Macro undefined -> if_gnt stays 0 for all 20 cycles.
5. Reset mid-read: read granted, rst_n pulled low before the next edge -> if_rvalid and d_rvalid stay 0, mem_en=0 during reset; after release, a fetch of 0x4 returns RAM[1] normally.
6. Aliasing: d_addr=0x0000_1004 with ADDR_W=10 -> mem_addr=1.
